// File: rtl/rf_dump.sv
// Debug read-out engine: walks the register file read port over an inclusive,
// wrapping index range and streams each captured word out with its index.
module rf_dump #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] first,
   input  logic [AW-1:0] last,
   input  logic          abort,
   output logic [AW-1:0] RA,
   input  logic [DW-1:0] A,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_index,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t        r_state, w_state_next;
   logic [AW-1:0] r_idx,   w_idx_next;
   logic [AW-1:0] r_end,   w_end_next;
   logic [AW-1:0] r_index, w_index_next;
   logic [DW-1:0] r_data,  w_data_next;
   logic          r_valid, w_valid_next;
   logic          r_last,  w_last_next;
   logic          r_done,  w_done_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_end   <= '0;
         r_index <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_end   <= w_end_next;
         r_index <= w_index_next;
         r_data  <= w_data_next;
         r_valid <= w_valid_next;
         r_last  <= w_last_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_end_next   = r_end;
      w_index_next = r_index;
      w_data_next  = r_data;
      w_valid_next = r_valid;
      w_last_next  = r_last;
      w_done_next  = 1'b0;

      case (r_state)
         S_IDLE: begin
            // abort is meaningless here, so start always wins
            if (start) begin
               w_idx_next   = first;
               w_end_next   = last;
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else begin
               w_data_next  = A;
               w_index_next = r_idx;
               w_last_next  = (r_idx == r_end);
               w_valid_next = 1'b1;
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (abort) begin
               w_valid_next = 1'b0;
               w_state_next = S_IDLE;
            end else if (r_valid && out_ready) begin
               w_valid_next = 1'b0;
               if (r_last) begin
                  w_done_next  = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_idx_next   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                  w_state_next = S_FETCH;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign RA        = r_idx;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_index = r_index;
   assign out_last  = r_last;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: full, wrapping, backpressured, snapshot,
// aborted and reset-interrupted dumps against a behavioural register file.
module tb_rf_dump;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  first;
   logic [4:0]  last;
   logic        abort;
   logic [4:0]  RA;
   logic [31:0] A;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] rf [32];
   int n_assert;
   int n_fail;

   assign A = rf[RA];

   rf_dump #(.NREGS(32), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .first     (first),
      .last      (last),
      .abort     (abort),
      .RA        (RA),
      .A         (A),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ra"},    32'(RA),        32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data"},  out_data,       32'd0);
      chk({tag, "_index"}, 32'(out_index), 32'd0);
      chk({tag, "_last"},  32'(out_last),  32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
   endtask

   // Runs a complete dump with out_ready high and checks exact cycle timing.
   task automatic dump(input string tag, input logic [4:0] f, input logic [4:0] l);
      logic [4:0] d;
      logic [4:0] ix;
      int n;
      d = l - f;
      n = int'(d) + 1;
      first = f; last = l; start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_fetch_busy"},  32'(busy),      32'd1);
      chk({tag, "_fetch_ra"},    32'(RA),        32'(f));
      chk({tag, "_fetch_valid"}, 32'(out_valid), 32'd0);
      for (int k = 0; k < n; k++) begin
         ix = f + 5'(k);
         step();
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_index"}, 32'(out_index), 32'(ix));
         chk({tag, "_data"},  out_data,       rf[ix]);
         chk({tag, "_last"},  32'(out_last),  32'(k == n - 1));
         step();
         chk({tag, "_drop"},  32'(out_valid), 32'd0);
         chk({tag, "_done"},  32'(done),      32'(k == n - 1));
         chk({tag, "_busy"},  32'(busy),      32'(k != n - 1));
      end
      step();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      $display("dump %s first=%0d last=%0d words=%0d", tag, f, l, n);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      reset = 1'b0; start = 1'b0; first = '0; last = '0;
      abort = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      #2;
      chk_reset_vals("reset");
      @(negedge clk);
      reset = 1'b1;
      step();
      chk_reset_vals("idle");

      // full 32-word dump, done lands 64 edges after the start-sampling edge
      dump("full", 5'd0, 5'd31);

      // wrap range with r0 reading zero
      rf[0] = 32'h0;
      dump("wrap", 5'd30, 5'd1);

      // backpressure on a single-word dump
      first = 5'd5; last = 5'd5; start = 1'b1; out_ready = 1'b0;
      step(); start = 1'b0;
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_data",  out_data,       32'h1005);
         chk("bp_hold_index", 32'(out_index), 32'd5);
         chk("bp_hold_last",  32'(out_last),  32'd1);
      end
      out_ready = 1'b1;
      step();
      chk("bp_accept_valid", 32'(out_valid), 32'd0);
      chk("bp_done",         32'(done),      32'd1);
      $display("backpressure word accepted after 10 stalled cycles");

      // snapshot: a write after capture does not alter the held word
      first = 5'd7; last = 5'd7; start = 1'b1; out_ready = 1'b0;
      step(); start = 1'b0;
      step();
      rf[7] = 32'hDEAD;
      step();
      chk("snap_old", out_data, 32'h1007);
      out_ready = 1'b1;
      step();
      chk("snap_old_done", 32'(done), 32'd1);
      $display("snapshot held old value %h", out_data);

      // snapshot: a write at the negedge inside FETCH is captured
      rf[7] = 32'h1007;
      step();
      start = 1'b1;
      step(); start = 1'b0;
      @(negedge clk);
      rf[7] = 32'hDEAD;
      step();
      chk("snap_new", out_data, 32'hDEAD);
      step();
      chk("snap_new_done", 32'(done), 32'd1);
      $display("snapshot captured new value %h", out_data);
      rf[7] = 32'h1007;

      // abort in HOLD of the third word beats a same-cycle handshake
      first = 5'd10; last = 5'd20; start = 1'b1; out_ready = 1'b1;
      step(); start = 1'b0;
      for (int c = 0; c < 5; c++) step();
      chk("abort_third_index", 32'(out_index), 32'd12);
      chk("abort_third_valid", 32'(out_valid), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_done",  32'(done),      32'd0);
      chk("abort_ra",    32'(RA),        32'd12);
      step();
      chk("abort_done_later", 32'(done), 32'd0);
      $display("abort taken on index 12");
      dump("post_abort", 5'd3, 5'd4);

      // asynchronous reset in the middle of a dump
      first = 5'd20; last = 5'd25; start = 1'b1; out_ready = 1'b1;
      step(); start = 1'b0;
      step();
      step();
      chk("mid_ra", 32'(RA), 32'd21);
      #3;
      reset = 1'b0;
      #1;
      chk_reset_vals("midreset");
      @(negedge clk);
      reset = 1'b1;
      step();
      chk_reset_vals("post_reset_idle");
      $display("reset during dump cleared outputs");
      dump("post_reset", 5'd2, 5'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
